rf_pulse_counter: RTL and testbench
===================================

# rf_pulse_counter

Digital back-end stage for the analog RF readout macro. Takes the readout's comparator/detector output as an asynchronous 1-bit signal and synchronizes it. Counts its rising edges over a programmable gate window and latches the result with a done pulse. The count is then read out on the tile's digital outputs. It is the first clocked stage after the analog readout and sits between the analog pin path and the tile's uo_out/uio pins.

## Interface
- `CNT_W`, default 16: width of the pulse counter and the `count` result.
- `GATE_W`, default 16: width of the gate-window length and the window counter.

Ports:
- `clk`  in  1  tile clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `comp_in`  in  1  comparator output from the analog readout; asynchronous to `clk`.
- `start`  in  1  level-sampled request to begin a measurement.
- `gate_len`  in  GATE_W  window length in clk cycles; sampled on accepted `start`.
- `busy`  out  1  high while a measurement is in progress.
- `done`  out  1  one-cycle pulse when `count` is updated.
- `count`  out  CNT_W  latched edge count of the last completed measurement.
- `overflow`  out  1  latched with `count`; set if the accumulator saturated.

## Operation
- Input path:
  - `comp_in` passes through a 2-flop synchronizer (`s1`, `s2`), then a delay flop `s3`.
  - Edge pulse `edge = s2 & ~s3`, one cycle per rising edge.
- FSM states: IDLE, COUNT, DONE.
  - IDLE: `busy=0`. If `start=1`, load window counter with `gate_len` and clear the accumulator and overflow flag.
    - Next state is COUNT, or DONE if `gate_len=0`.
  - COUNT: `busy=1`. Each cycle with `edge=1` increments the accumulator.
    - Window counter decrements each cycle.
    - When the window counter equals 1, next state is DONE, and this last cycle's edge is still counted.
    - COUNT therefore lasts exactly `gate_len` cycles.
  - DONE: `busy=0`, `done=1`. `count` and `overflow` load from the accumulator and overflow flag. Next state is IDLE.
- Accumulator saturates at 2^CNT_W−1. An increment at saturation sets the overflow flag and holds the value.
- `start` in COUNT or DONE is ignored and is not queued.
- `gate_len` changes after acceptance have no effect on the running measurement.
- `count` and `overflow` hold their values until the next DONE.
- Reset mid-measurement aborts the measurement, returns to IDLE and clears all registers. No `done` pulse is produced.

## Timing
- Reset values: `busy=0`, `done=0`, `count=0`, `overflow=0`, FSM=IDLE, synchronizer flops=0.
- `start` sampled high at edge N: COUNT spans cycles N+1 … N+`gate_len`.
- `done` is high for cycle N+`gate_len`+1, with `count` and `overflow` valid from the same edge.
- Earliest new `start` is accepted at edge N+`gate_len`+2.
- `gate_len=0`: `done` is high at cycle N+1 with `count=0`.
- Input latency: a `comp_in` rising edge captured by `s1` at edge k produces `edge` high in cycle k+2 (with the filter compiled in, the `edge` pulse comes one cycle later). It is counted only if that cycle lies inside the COUNT window.
- Minimum countable pulse: comp_in high ≥2 and low ≥2 clk cycles. Shorter pulses are not guaranteed.

## Configuration
- `RF_PULSE_FILTER_EN`:
  - Defined: a glitch filter is inserted after `s2`. The filtered level changes only when `s2` has held the new value for 2 consecutive cycles. This adds 1 cycle of input latency, and 1-cycle glitches are never counted.
  - Undefined: `edge` is derived directly from `s2`/`s3` as above. Any synchronized high lasting ≥1 cycle counts.

## Test plan
- Reset with `comp_in` toggling:
  - During reset, all outputs are 0.
  - After release with no `start`, `busy`, `done` and `count` stay 0.
- `gate_len=100`, `start` at edge 0, 7 clean pulses (4 high/4 low) beginning cycle 5 → `done` at cycle 101 only, `count=7`, `overflow=0`, `busy` high cycles 1–100.
- Sanity check with `CNT_W=4`: 20 pulses inside the window → `count=15`, `overflow=1`. Next measurement with 3 pulses → `count=3`, `overflow=0`.
- Boundary cases:
  - `gate_len=0` → `done` at cycle 1 with `count=0`.
  - `gate_len=1` with an edge pulse in cycle 1 → `count=1`.
  - An edge pulse in the cycle after the window → not counted.
- `start` re-asserted during COUNT, plus `rst_n` pulsed low mid-COUNT:
  - The extra `start` is ignored.
  - Reset clears `busy`/`count`/`overflow`, and no `done` appears.
  - A fresh measurement then works normally.
- Five 1-cycle-high glitches with 4-cycle gaps inside the window:
  - Without `RF_PULSE_FILTER_EN`: `count=5`.
  - With the macro defined: `count=0`.

Source files
------------

// File: rtl/rf_pulse_counter_if.sv
// rtl/rf_pulse_counter_if.sv - measurement request/result bundle for rf_pulse_counter
interface rf_pulse_counter_if #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
);
  logic              comp_in;
  logic              start;
  logic [GATE_W-1:0] gate_len;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  count;
  logic              overflow;

  modport master (
    output comp_in, start, gate_len,
    input  busy, done, count, overflow
  );

  modport slave (
    input  comp_in, start, gate_len,
    output busy, done, count, overflow
  );
endinterface

// File: rtl/rf_pulse_counter.sv
// rtl/rf_pulse_counter.sv - synchronized rising-edge counter over a gate window; RF_PULSE_FILTER_EN adds a 2-cycle glitch filter
module rf_pulse_counter #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 16
) (
  input logic               clk,
  input logic               rst_n,
  rf_pulse_counter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

  localparam logic [CNT_W-1:0] ACC_MAX = '1;

  state_t            r_state;
  logic              r_s1, r_s2, r_s3;
  logic [GATE_W-1:0] r_win;
  logic [CNT_W-1:0]  r_acc;
  logic              r_ovf;
  logic              r_busy, r_done, r_overflow;
  logic [CNT_W-1:0]  r_count;
  logic              w_edge;
  logic              w_sat;
  logic [CNT_W-1:0]  w_acc_nxt;
  logic              w_ovf_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= bus.comp_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

`ifdef RF_PULSE_FILTER_EN
  // r_s3 is s2 one cycle ago, so s2==s3 means s2 has held its value for two cycles.
  logic r_filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_filt <= 1'b0;
    end else if (r_s2 == r_s3) begin
      r_filt <= r_s2;
    end
  end

  assign w_edge = r_s2 & r_s3 & ~r_filt;
`else
  assign w_edge = r_s2 & ~r_s3;
`endif

  assign w_sat     = w_edge && (r_acc == ACC_MAX);
  assign w_acc_nxt = (w_edge && !w_sat) ? r_acc + CNT_W'(1) : r_acc;
  assign w_ovf_nxt = r_ovf | w_sat;

  // Results load on entry to DONE so done/count/overflow become valid together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_win      <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_win <= bus.gate_len;
            r_acc <= '0;
            r_ovf <= 1'b0;
            if (bus.gate_len == '0) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_count    <= '0;
              r_overflow <= 1'b0;
            end else begin
              r_state <= S_COUNT;
              r_busy  <= 1'b1;
            end
          end
        end
        S_COUNT: begin
          r_acc <= w_acc_nxt;
          r_ovf <= w_ovf_nxt;
          r_win <= r_win - GATE_W'(1);
          if (r_win == GATE_W'(1)) begin
            r_state    <= S_DONE;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_count    <= w_acc_nxt;
            r_overflow <= w_ovf_nxt;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.count    = r_count;
  assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_rf_pulse_counter.sv
// tb/tb_rf_pulse_counter.sv - scoreboard bench for rf_pulse_counter, 16-bit and 4-bit counter instances
module tb_rf_pulse_counter;
  typedef struct {
    int          cnt;
    bit          ovf;
    int unsigned done_cyc;
    int          busy_cyc;
  } exp_t;

`ifdef RF_PULSE_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        comp_in;
  logic        start;
  logic [15:0] gate_len;

  int          total = 0;
  int          bad   = 0;
  int unsigned cyc   = 0;
  int          bc [2];
  exp_t        q_a [$];
  exp_t        q_b [$];

  rf_pulse_counter_if #(.CNT_W(16), .GATE_W(16)) if_a ();
  rf_pulse_counter_if #(.CNT_W(4),  .GATE_W(16)) if_b ();

  assign if_a.comp_in  = comp_in;
  assign if_a.start    = start;
  assign if_a.gate_len = gate_len;
  assign if_b.comp_in  = comp_in;
  assign if_b.start    = start;
  assign if_b.gate_len = gate_len;

  rf_pulse_counter #(.CNT_W(16), .GATE_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  rf_pulse_counter #(.CNT_W(4),  .GATE_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1);
  end

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Counts rising edges of the level sequence (filtered when the glitch filter is built)
  // whose detector pulse lands on one of the gate edges s+1 .. s+gl.
  function automatic int model_count(input bit w[$], input int s, input int gl);
    int n   = 0;
    bit lvl = 1'b0;
    for (int j = 0; j < w.size(); j++) begin
      bit rise;
      rise = 1'b0;
`ifdef RF_PULSE_FILTER_EN
      if (j + 1 < w.size() && w[j] == w[j+1] && w[j] != lvl) begin
        lvl  = w[j];
        rise = lvl;
      end
`else
      if (j > 0) rise = w[j] && !w[j-1];
`endif
      if (rise && (j + LAT >= s + 1) && (j + LAT <= s + gl)) n++;
    end
    return n;
  endfunction

  task automatic observe(input int id, input bit busy, input bit done, input longint cnt, input bit ovf);
    exp_t  e;
    string nm;
    nm = (id == 0) ? "a" : "b";
    if (busy) bc[id]++;
    if (done) begin
      if ((id == 0 && q_a.size() == 0) || (id == 1 && q_b.size() == 0)) begin
        total++;
        bad++;
        $display("FAIL unexpected_done_%s actual=done expected=no_done cyc=%0d", nm, cyc);
      end else begin
        e = (id == 0) ? q_a.pop_front() : q_b.pop_front();
        check({"count_", nm}, cnt, e.cnt);
        check({"overflow_", nm}, ovf, e.ovf);
        check({"done_cycle_", nm}, cyc, e.done_cyc);
        check({"busy_cycles_", nm}, bc[id], e.busy_cyc);
      end
      bc[id] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      bc[0] = 0;
      bc[1] = 0;
    end else begin
      observe(0, if_a.busy, if_a.done, if_a.count, if_a.overflow);
      observe(1, if_b.busy, if_b.done, if_b.count, if_b.overflow);
    end
  end

  task automatic build_random(input int gl, output bit w[$], output int s);
    int len;
    s   = 2 + $urandom_range(0, 3);
    len = s + gl + 8;
    w   = {};
    w.push_back(1'b0);
    while (w.size() < len - 5) begin
      bit lvl;
      int r;
      lvl = ~w[$];
      r   = $urandom_range(1, 5);
      repeat (r) if (w.size() < len - 5) w.push_back(lvl);
    end
    repeat (5) w.push_back(1'b0);
  endtask

  task automatic build_pulses(input int s, input int gl, input int n, input int hi,
                              input int lo, input int first, output bit w[$]);
    w = {};
    repeat (first) w.push_back(1'b0);
    repeat (n) begin
      repeat (hi) w.push_back(1'b1);
      repeat (lo) w.push_back(1'b0);
    end
    while (w.size() < s + gl + 8) w.push_back(1'b0);
    repeat (4) w.push_back(1'b0);
  endtask

  task automatic run(input bit w[$], input int s, input int gl, input int extra);
    exp_t e;
    int   raw;
    raw = model_count(w, s, gl);
    for (int j = 0; j < w.size(); j++) begin
      @(negedge clk);
      comp_in  = w[j];
      start    = (j == s) || (j > s && j <= s + extra);
      gate_len = (j == s) ? 16'(gl) : 16'($urandom);
      if (j == s) begin
        e.done_cyc = cyc + gl + 1;
        e.busy_cyc = gl;
        e.cnt      = raw;
        e.ovf      = 1'b0;
        q_a.push_back(e);
        e.cnt = (raw > 15) ? 15 : raw;
        e.ovf = (raw > 15);
        q_b.push_back(e);
      end
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"},     {if_a.busy, if_b.busy}, 0);
    check({tag, "_done"},     {if_a.done, if_b.done}, 0);
    check({tag, "_count"},    {if_a.count, if_b.count}, 0);
    check({tag, "_overflow"}, {if_a.overflow, if_b.overflow}, 0);
  endtask

  initial begin
    bit w[$];
    int s;
    int gl;

    rst_n    = 1'b0;
    comp_in  = 1'b0;
    start    = 1'b0;
    gate_len = '0;

    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      comp_in = ~comp_in;
      check_idle_outputs("in_reset");
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      comp_in = i[1];
    end
    check_idle_outputs("after_reset");
    comp_in = 1'b0;
    repeat (4) @(negedge clk);

    build_pulses(3, 100, 7, 4, 4, 3 + 3, w);
    run(w, 3, 100, 0);

    build_pulses(3, 200, 20, 4, 4, 4, w);
    run(w, 3, 200, 0);

    build_pulses(3, 40, 3, 4, 4, 4, w);
    run(w, 3, 40, 0);

    // Abort a measurement: extra start during COUNT, then reset while busy.
    @(negedge clk);
    start    = 1'b1;
    gate_len = 16'd50;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      comp_in = i[1];
      start   = (i == 6);
    end
    @(negedge clk);
    rst_n   = 1'b0;
    start   = 1'b0;
    comp_in = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (60) @(negedge clk);
    check_idle_outputs("after_abort");

    build_pulses(4, 0, 2, 2, 2, 2, w);
    run(w, 4, 0, 0);

    build_pulses(4, 1, 1, 2, 4, 4 + 1 - LAT, w);
    run(w, 4, 1, 0);

    build_pulses(4, 10, 1, 2, 4, 4 + 11 - LAT, w);
    run(w, 4, 10, 0);

    build_pulses(3, 40, 5, 1, 4, 4, w);
    run(w, 3, 40, 0);

    build_random(30, w, s);
    run(w, s, 30, 5);

    for (int k = 0; k < 20; k++) begin
      gl = $urandom_range(0, 40);
      build_random(gl, w, s);
      run(w, s, gl, (gl > 2) ? $urandom_range(0, gl - 1) : 0);
    end

    for (int i = 0; i < 200 && (q_a.size() != 0 || q_b.size() != 0); i++) @(negedge clk);
    check("pending_a", q_a.size(), 0);
    check("pending_b", q_b.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
